// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the CPU memory responder: FSM states, access sizes
// and requester identifiers.
package cpu_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  localparam logic [1:0] SZ_B  = 2'd0;
  localparam logic [1:0] SZ_HW = 2'd1;
  localparam logic [1:0] SZ_W  = 2'd2;

  localparam logic [1:0] SRC_I  = 2'd0;
  localparam logic [1:0] SRC_DR = 2'd1;
  localparam logic [1:0] SRC_DW = 2'd2;

  // Word wins when both size strobes are set.
  function automatic logic [1:0] size_code(input logic w, input logic hw);
    logic [1:0] code;
    if (w) begin
      code = SZ_W;
    end else if (hw) begin
      code = SZ_HW;
    end else begin
      code = SZ_B;
    end
    return code;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between right-justified CPU data and the 32-bit SRAM word,
// for both the write (mask + replication) and read (extraction) directions.
module mem_lane_align (
  input  logic [1:0]  size,
  input  logic [1:0]  adr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  we,
  output logic [31:0] wdata_pos,
  output logic [31:0] rdata_ext
);
  import cpu_mem_pkg::*;

  // Write lane mask and replicated store data for the requested size.
  always_comb begin
    we        = 4'b0000;
    wdata_pos = 32'd0;
    case (size)
      SZ_W: begin
        we        = 4'b1111;
        wdata_pos = wdata;
      end
      SZ_HW: begin
        we        = adr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_pos = {2{wdata[15:0]}};
      end
      SZ_B: begin
        we        = 4'b0001 << adr_lo;
        wdata_pos = {4{wdata[7:0]}};
      end
      default: begin
        we        = 4'b0000;
        wdata_pos = 32'd0;
      end
    endcase
  end

  // Selected read lane moved down to bit 0, upper bits zero.
  always_comb begin
    rdata_ext = 32'd0;
    case (size)
      SZ_W: begin
        rdata_ext = rdata;
      end
      SZ_HW: begin
        if (adr_lo[1]) begin
          rdata_ext = {16'd0, rdata[31:16]};
        end else begin
          rdata_ext = {16'd0, rdata[15:0]};
        end
      end
      SZ_B: begin
        rdata_ext = {24'd0, rdata[{adr_lo, 3'b000} +: 8]};
      end
      default: begin
        rdata_ext = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder: arbitrates instruction-read, data-read and data-write
// requests and serves them one at a time from a single-port byte-writable SRAM.
module cpu_mem_responder #(
  parameter int MEM_ADR_W = 14,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_read_req,
  input  logic                 i_read_w,
  input  logic                 i_read_hw,
  input  logic [31:0]          i_read_adr,
  input  logic                 d_read_req,
  input  logic                 d_read_w,
  input  logic                 d_read_hw,
  input  logic [31:0]          d_read_adr,
  input  logic                 d_write_req,
  input  logic                 d_write_w,
  input  logic                 d_write_hw,
  input  logic [31:0]          d_write_adr,
  input  logic [31:0]          d_write_data,
  output logic                 read_valid,
  output logic [31:0]          read_data,
  output logic                 write_finish,
  output logic                 mem_err,
  output logic                 mem_en,
  output logic [3:0]           mem_we,
  output logic [MEM_ADR_W-1:0] mem_adr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);
  import cpu_mem_pkg::*;

  localparam logic [1:0] RD_LAT_C = 2'(RD_LAT);

  state_e               state_r;
  logic [1:0]           wait_cnt_r;
  logic [1:0]           src_r;
  logic [1:0]           size_r;
  logic [1:0]           adr_lo_r;
  logic                 oor_r;
  logic                 read_valid_r;
  logic [31:0]          read_data_r;
  logic                 write_finish_r;
  logic                 mem_err_r;
  logic                 mem_en_r;
  logic [3:0]           mem_we_r;
  logic [MEM_ADR_W-1:0] mem_adr_r;
  logic [31:0]          mem_wdata_r;

  logic                 sel_valid_s;
  logic [1:0]           sel_src_s;
  logic                 sel_w_s;
  logic                 sel_hw_s;
  logic [31:0]          sel_adr_s;
  logic [1:0]           sel_size_s;
  logic                 sel_oor_s;
  logic [1:0]           al_size_s;
  logic [1:0]           al_adr_s;
  logic [3:0]           al_we_s;
  logic [31:0]          al_wdata_s;
  logic [31:0]          al_rdata_s;

  // Fixed-priority pick among the held requests: write, then data read, then fetch.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_src_s   = SRC_I;
    sel_w_s     = 1'b0;
    sel_hw_s    = 1'b0;
    sel_adr_s   = 32'd0;
    if (d_write_req) begin
      sel_valid_s = 1'b1;
      sel_src_s   = SRC_DW;
      sel_w_s     = d_write_w;
      sel_hw_s    = d_write_hw;
      sel_adr_s   = d_write_adr;
    end else if (d_read_req) begin
      sel_valid_s = 1'b1;
      sel_src_s   = SRC_DR;
      sel_w_s     = d_read_w;
      sel_hw_s    = d_read_hw;
      sel_adr_s   = d_read_adr;
    end else if (i_read_req) begin
      sel_valid_s = 1'b1;
      sel_src_s   = SRC_I;
      sel_w_s     = i_read_w;
      sel_hw_s    = i_read_hw;
      sel_adr_s   = i_read_adr;
    end else begin
      sel_valid_s = 1'b0;
    end
  end

  assign sel_size_s = size_code(sel_w_s, sel_hw_s);
  assign sel_oor_s  = (sel_adr_s >> (MEM_ADR_W + 2)) != 32'd0;

  // The aligner sees the incoming request while idle (to prepare the write
  // lanes for ISSUE) and the latched request afterwards (for read extraction).
  always_comb begin
    if (state_r == ST_IDLE) begin
      al_size_s = sel_size_s;
      al_adr_s  = sel_adr_s[1:0];
    end else begin
      al_size_s = size_r;
      al_adr_s  = adr_lo_r;
    end
  end

  mem_lane_align u_align (
    .size      (al_size_s),
    .adr_lo    (al_adr_s),
    .wdata     (d_write_data),
    .rdata     (mem_rdata),
    .we        (al_we_s),
    .wdata_pos (al_wdata_s),
    .rdata_ext (al_rdata_s)
  );

  // Transaction sequencer with all interface outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      wait_cnt_r     <= 2'd0;
      src_r          <= SRC_I;
      size_r         <= SZ_B;
      adr_lo_r       <= 2'd0;
      oor_r          <= 1'b0;
      read_valid_r   <= 1'b0;
      read_data_r    <= 32'd0;
      write_finish_r <= 1'b0;
      mem_err_r      <= 1'b0;
      mem_en_r       <= 1'b0;
      mem_we_r       <= 4'b0000;
      mem_adr_r      <= '0;
      mem_wdata_r    <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sel_valid_s) begin
            src_r     <= sel_src_s;
            size_r    <= sel_size_s;
            adr_lo_r  <= sel_adr_s[1:0];
            oor_r     <= sel_oor_s;
            mem_adr_r <= sel_adr_s[MEM_ADR_W+1:2];
            mem_en_r  <= !sel_oor_s;
            mem_we_r  <= (sel_src_s == SRC_DW && !sel_oor_s) ? al_we_s : 4'b0000;
            if (sel_src_s == SRC_DW) begin
              mem_wdata_r <= al_wdata_s;
            end
            state_r   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_en_r <= 1'b0;
          mem_we_r <= 4'b0000;
          if (oor_r) begin
            mem_err_r <= 1'b1;
            if (src_r == SRC_DW) begin
              write_finish_r <= 1'b1;
            end else begin
              read_valid_r <= 1'b1;
              read_data_r  <= 32'd0;
            end
            state_r <= ST_RESP;
          end else if (src_r == SRC_DW) begin
            write_finish_r <= 1'b1;
            state_r        <= ST_RESP;
          end else begin
            wait_cnt_r <= RD_LAT_C;
            state_r    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_r == 2'd1) begin
            read_data_r  <= al_rdata_s;
            read_valid_r <= 1'b1;
            wait_cnt_r   <= 2'd0;
            state_r      <= ST_RESP;
          end else begin
            wait_cnt_r <= wait_cnt_r - 2'd1;
          end
        end
        ST_RESP: begin
          read_valid_r   <= 1'b0;
          write_finish_r <= 1'b0;
          mem_err_r      <= 1'b0;
          state_r        <= ST_GAP;
        end
        // Requests are still high here; the CPU drops them one cycle after the pulse.
        ST_GAP: begin
          state_r <= ST_IDLE;
        end
        default: begin
          read_valid_r   <= 1'b0;
          write_finish_r <= 1'b0;
          mem_err_r      <= 1'b0;
          mem_en_r       <= 1'b0;
          mem_we_r       <= 4'b0000;
          state_r        <= ST_IDLE;
        end
      endcase
    end
  end

  assign read_valid   = read_valid_r;
  assign read_data    = read_data_r;
  assign write_finish = write_finish_r;
  assign mem_err      = mem_err_r;
  assign mem_en       = mem_en_r;
  assign mem_we       = mem_we_r;
  assign mem_adr      = mem_adr_r;
  assign mem_wdata    = mem_wdata_r;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder with a behavioural byte-writable SRAM.
module tb_cpu_mem_responder;

  localparam int MEM_ADR_W = 14;
  localparam int RD_LAT    = 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 i_read_req = 1'b0, i_read_w = 1'b0, i_read_hw = 1'b0;
  logic [31:0]          i_read_adr = 32'd0;
  logic                 d_read_req = 1'b0, d_read_w = 1'b0, d_read_hw = 1'b0;
  logic [31:0]          d_read_adr = 32'd0;
  logic                 d_write_req = 1'b0, d_write_w = 1'b0, d_write_hw = 1'b0;
  logic [31:0]          d_write_adr = 32'd0;
  logic [31:0]          d_write_data = 32'd0;
  logic                 read_valid, write_finish, mem_err, mem_en;
  logic [31:0]          read_data, mem_wdata;
  logic [3:0]           mem_we;
  logic [MEM_ADR_W-1:0] mem_adr;
  logic [31:0]          mem_rdata;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  cpu_mem_responder #(.MEM_ADR_W(MEM_ADR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read_req(i_read_req), .i_read_w(i_read_w), .i_read_hw(i_read_hw), .i_read_adr(i_read_adr),
    .d_read_req(d_read_req), .d_read_w(d_read_w), .d_read_hw(d_read_hw), .d_read_adr(d_read_adr),
    .d_write_req(d_write_req), .d_write_w(d_write_w), .d_write_hw(d_write_hw),
    .d_write_adr(d_write_adr), .d_write_data(d_write_data),
    .read_valid(read_valid), .read_data(read_data), .write_finish(write_finish),
    .mem_err(mem_err), .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] sram [0:(1<<MEM_ADR_W)-1];

  // SRAM with one cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= sram[mem_adr];
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) sram[mem_adr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  typedef struct { bit is_rd; logic [31:0] data; logic err; int c; } ev_t;
  typedef struct { logic [MEM_ADR_W-1:0] adr; logic [3:0] we; logic [31:0] wdata; int c; } en_t;
  ev_t exp_q[$];
  ev_t obs_q[$];
  en_t en_q[$];
  int rv_cnt = 0, wf_cnt = 0, we_nz_cnt = 0;

  // Completion and SRAM-access monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (read_valid || write_finish) obs_q.push_back('{read_valid, read_data, mem_err, cyc});
    if (read_valid) rv_cnt++;
    if (write_finish) wf_cnt++;
    if (mem_en) en_q.push_back('{mem_adr, mem_we, mem_wdata, cyc});
    if (mem_we != 4'd0) we_nz_cnt++;
  end

  function automatic ev_t pop_obs();
    if (obs_q.size() == 0) return '{1'b0, 32'd0, 1'b0, -1};
    return obs_q.pop_front();
  endfunction

  function automatic en_t pop_en();
    if (en_q.size() == 0) return '{'0, 4'd0, 32'd0, -1};
    return en_q.pop_front();
  endfunction

  task automatic drop_all();
    i_read_req = 1'b0;
    d_read_req = 1'b0;
    d_write_req = 1'b0;
  endtask

  task automatic drive(input int src, input logic w, input logic hw,
                       input logic [31:0] adr, input logic [31:0] data);
    case (src)
      0: begin i_read_w = w; i_read_hw = hw; i_read_adr = adr; i_read_req = 1'b1; end
      1: begin d_read_w = w; d_read_hw = hw; d_read_adr = adr; d_read_req = 1'b1; end
      default: begin
        d_write_w = w; d_write_hw = hw; d_write_adr = adr; d_write_data = data; d_write_req = 1'b1;
      end
    endcase
  endtask

  // Hold one request until its completion pulse, then drop it like the CPU does.
  task automatic serve(input int src, input logic w, input logic hw,
                       input logic [31:0] adr, input logic [31:0] data);
    int rv0, wf0;
    rv0 = rv_cnt;
    wf0 = wf_cnt;
    drive(src, w, hw, adr, data);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (rv_cnt != rv0 || wf_cnt != wf0) break;
    end
    drop_all();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({read_valid, read_data, write_finish, mem_err, mem_en, mem_we, mem_adr, mem_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: rv=%0b rd=%h wf=%0b err=%0b en=%0b we=%b adr=%h wd=%h, want all 0",
               read_valid, read_data, write_finish, mem_err, mem_en, mem_we, mem_adr, mem_wdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int src; logic w; logic hw; logic [31:0] adr; logic [31:0] data;
    logic [31:0] rdat; logic [3:0] we; logic [31:0] wpos;
  } op_t;

  task automatic test_lanes();
    op_t ops[$];
    op_t op;
    ev_t e, o;
    en_t en;
    int start;
    logic [MEM_ADR_W-1:0] ea;
    ops.push_back('{2, 1'b1, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 32'd0,        4'b1111, 32'hDEADBEEF});
    ops.push_back('{0, 1'b1, 1'b0, 32'h0000_0010, 32'd0,        32'hDEADBEEF, 4'b0000, 32'd0});
    ops.push_back('{2, 1'b1, 1'b0, 32'h0000_0100, 32'h11223344, 32'd0,        4'b1111, 32'h11223344});
    ops.push_back('{2, 1'b0, 1'b0, 32'h0000_0103, 32'h000000A5, 32'd0,        4'b1000, 32'hA5A5A5A5});
    ops.push_back('{1, 1'b1, 1'b0, 32'h0000_0100, 32'd0,        32'hA5223344, 4'b0000, 32'd0});
    ops.push_back('{2, 1'b1, 1'b0, 32'h0000_0100, 32'h1234ABCD, 32'd0,        4'b1111, 32'h1234ABCD});
    ops.push_back('{1, 1'b0, 1'b1, 32'h0000_0102, 32'd0,        32'h00001234, 4'b0000, 32'd0});
    ops.push_back('{1, 1'b0, 1'b0, 32'h0000_0101, 32'd0,        32'h000000AB, 4'b0000, 32'd0});
    ops.push_back('{2, 1'b0, 1'b1, 32'h0000_0102, 32'h0000BEEF, 32'd0,        4'b1100, 32'hBEEFBEEF});
    ops.push_back('{1, 1'b1, 1'b0, 32'h0000_0100, 32'd0,        32'hBEEFABCD, 4'b0000, 32'd0});
    ops.push_back('{1, 1'b0, 1'b1, 32'h0000_0100, 32'd0,        32'h0000ABCD, 4'b0000, 32'd0});
    ops.push_back('{2, 1'b0, 1'b0, 32'h0000_0101, 32'hFFFFFF5A, 32'd0,        4'b0010, 32'h5A5A5A5A});
    ops.push_back('{0, 1'b1, 1'b1, 32'h0000_0102, 32'd0,        32'hBEEF5ACD, 4'b0000, 32'd0});
    ops.push_back('{1, 1'b0, 1'b0, 32'h0000_0103, 32'd0,        32'h000000BE, 4'b0000, 32'd0});
    ops.push_back('{2, 1'b0, 1'b1, 32'h0000_0000, 32'h12345678, 32'd0,        4'b0011, 32'h56785678});
    ops.push_back('{0, 1'b0, 1'b1, 32'h0000_0001, 32'd0,        32'h00005678, 4'b0000, 32'd0});
    foreach (ops[i]) begin
      op = ops[i];
      en_q.delete();
      start = cyc;
      if (op.src == 2) exp_q.push_back('{1'b0, 32'd0, 1'b0, start + 2});
      else exp_q.push_back('{1'b1, op.rdat, 1'b0, start + 2 + RD_LAT});
      serve(op.src, op.w, op.hw, op.adr, op.data);
      e = exp_q.pop_front();
      o = pop_obs();
      n_cmp++;
      if (o.is_rd !== e.is_rd || (e.is_rd && o.data !== e.data) || o.err !== e.err || o.c !== e.c) begin
        n_err++;
        $display("FAIL lane_op%0d: got rd=%0b data=%h err=%0b cyc=%0d, want rd=%0b data=%h err=%0b cyc=%0d",
                 i, o.is_rd, o.data, o.err, o.c, e.is_rd, e.data, e.err, e.c);
      end
      en = pop_en();
      ea = op.adr[MEM_ADR_W+1:2];
      n_cmp++;
      if (en.adr !== ea || en.we !== op.we || en.c !== start + 1 || (op.src == 2 && en.wdata !== op.wpos)) begin
        n_err++;
        $display("FAIL issue_op%0d: got adr=%h we=%b wdata=%h cyc=%0d, want adr=%h we=%b wdata=%h cyc=%0d",
                 i, en.adr, en.we, en.wdata, en.c, ea, op.we, op.wpos, start + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    ev_t e, o;
    int start, rv0, wf0;
    en_q.delete();
    rv0 = rv_cnt;
    wf0 = wf_cnt;
    start = cyc;
    exp_q.push_back('{1'b0, 32'd0, 1'b0, start + 2});
    exp_q.push_back('{1'b1, 32'hCAFEF00D, 1'b0, start + 4 + 2 + RD_LAT});
    drive(2, 1'b1, 1'b0, 32'h0000_0200, 32'hCAFEF00D);
    drive(0, 1'b1, 1'b0, 32'h0000_0200, 32'd0);
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (wf_cnt != wf0) d_write_req = 1'b0;
      if (rv_cnt != rv0) i_read_req = 1'b0;
    end
    drop_all();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = pop_obs();
      n_cmp++;
      if (o.is_rd !== e.is_rd || (e.is_rd && o.data !== e.data) || o.err !== e.err || o.c !== e.c) begin
        n_err++;
        $display("FAIL priority: got rd=%0b data=%h err=%0b cyc=%0d, want rd=%0b data=%h err=%0b cyc=%0d",
                 o.is_rd, o.data, o.err, o.c, e.is_rd, e.data, e.err, e.c);
      end
    end
    n_cmp++;
    if (obs_q.size() != 0 || en_q.size() != 2) begin
      n_err++;
      $display("FAIL priority_no_dup: extra completions=%0d sram accesses=%0d, want 0 and 2",
               obs_q.size(), en_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    ev_t e, o;
    int start, rv0;
    drive(0, 1'b1, 1'b0, 32'h0000_0010, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({read_valid, read_data, write_finish, mem_err, mem_en, mem_we, mem_adr, mem_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: rv=%0b rd=%h wf=%0b err=%0b en=%0b we=%b adr=%h wd=%h, want all 0",
               read_valid, read_data, write_finish, mem_err, mem_en, mem_we, mem_adr, mem_wdata);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = cyc;
    rv0 = rv_cnt;
    exp_q.push_back('{1'b1, 32'hDEADBEEF, 1'b0, start + 2 + RD_LAT});
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (rv_cnt != rv0) i_read_req = 1'b0;
    end
    drop_all();
    e = exp_q.pop_front();
    o = pop_obs();
    n_cmp++;
    if (o.is_rd !== e.is_rd || o.data !== e.data || o.err !== e.err || o.c !== e.c) begin
      n_err++;
      $display("FAIL reset_mid_retry: got rd=%0b data=%h err=%0b cyc=%0d, want rd=%0b data=%h err=%0b cyc=%0d",
               o.is_rd, o.data, o.err, o.c, e.is_rd, e.data, e.err, e.c);
    end
    n_cmp++;
    if (rv_cnt - rv0 != 1) begin
      n_err++;
      $display("FAIL reset_mid_count: read_valid pulses=%0d, want 1", rv_cnt - rv0);
    end
    obs_q.delete();
  endtask

  task automatic test_oor();
    ev_t e, o;
    int start, nz0;
    // Out-of-range read, then out-of-range write, then a check that word 0 is intact.
    for (int t = 0; t < 3; t++) begin
      en_q.delete();
      nz0 = we_nz_cnt;
      start = cyc;
      case (t)
        0: begin
          exp_q.push_back('{1'b1, 32'd0, 1'b1, start + 2});
          serve(1, 1'b1, 1'b0, 32'h0010_0000, 32'd0);
        end
        1: begin
          exp_q.push_back('{1'b0, 32'd0, 1'b1, start + 2});
          serve(2, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0055);
        end
        default: begin
          exp_q.push_back('{1'b1, 32'h0000_5678, 1'b0, start + 2 + RD_LAT});
          serve(1, 1'b0, 1'b1, 32'h0000_0000, 32'd0);
        end
      endcase
      e = exp_q.pop_front();
      o = pop_obs();
      n_cmp++;
      if (o.is_rd !== e.is_rd || (e.is_rd && o.data !== e.data) || o.err !== e.err || o.c !== e.c) begin
        n_err++;
        $display("FAIL oor_%0d: got rd=%0b data=%h err=%0b cyc=%0d, want rd=%0b data=%h err=%0b cyc=%0d",
                 t, o.is_rd, o.data, o.err, o.c, e.is_rd, e.data, e.err, e.c);
      end
      if (t < 2) begin
        n_cmp++;
        if (en_q.size() != 0 || we_nz_cnt != nz0) begin
          n_err++;
          $display("FAIL oor_%0d_no_access: mem_en cycles=%0d mem_we nonzero cycles=%0d, want 0 and 0",
                   t, en_q.size(), we_nz_cnt - nz0);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lanes();
    test_back_to_back();
    test_reset_mid();
    test_oor();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
